// File: rtl/minsoc_wb_pkg.sv
// Shared Wishbone definitions for the boot copier: copy FSM states, select mask
// and address stride.
package minsoc_wb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_GAP_R,
        ST_WR,
        ST_GAP_W,
        ST_DONE
    } copier_state_t;

    localparam logic [3:0]  WB_SEL_ALL = 4'hF;
    localparam logic [31:0] WB_ADR_INC = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] adr);
        return adr & ~32'h3;
    endfunction

endpackage

// File: rtl/minsoc_wb_xfer.sv
// One Wishbone classic transfer: holds stb/cyc until ack, err or timeout.
// The completion strobes are combinational so the owner FSM can advance on the same edge.
module minsoc_wb_xfer
    import minsoc_wb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic        launch,
    input  logic        launch_we,
    input  logic [31:0] launch_adr,
    input  logic [31:0] launch_dat,
    output logic        xfer_ok,
    output logic        xfer_fail,
    output logic [31:0] rd_data,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic             stb_reg;
    logic             we_reg;
    logic [31:0]      adr_reg;
    logic [31:0]      dat_reg;
    logic [31:0]      rd_data_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             tmo;

    // ack/err only count while strobing; err wins over ack, ack on the last
    // allowed cycle still counts as success.
    always_comb begin
        tmo       = (cnt_reg == CNT_W'(TIMEOUT - 1));
        xfer_ok   = stb_reg & wb_ack_i & ~wb_err_i;
        xfer_fail = stb_reg & (wb_err_i | (tmo & ~wb_ack_i));
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            stb_reg     <= 1'b0;
            we_reg      <= 1'b0;
            adr_reg     <= '0;
            dat_reg     <= '0;
            rd_data_reg <= '0;
            cnt_reg     <= '0;
        end else if (launch) begin
            stb_reg <= 1'b1;
            we_reg  <= launch_we;
            adr_reg <= launch_adr;
            dat_reg <= launch_dat;
            cnt_reg <= '0;
        end else if (stb_reg) begin
            if (xfer_ok || xfer_fail) begin
                stb_reg <= 1'b0;
                we_reg  <= 1'b0;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
            if (xfer_ok && !we_reg) begin
                rd_data_reg <= wb_dat_i;
            end
        end
    end

    assign rd_data  = rd_data_reg;
    assign wb_adr_o = adr_reg;
    assign wb_dat_o = dat_reg;
    assign wb_we_o  = we_reg;
    assign wb_sel_o = WB_SEL_ALL;
    assign wb_stb_o = stb_reg;
    assign wb_cyc_o = stb_reg;

endmodule

// File: rtl/wb_boot_copier.sv
// Boot-time block copier: reads len_words words from src_adr and writes them to
// dst_adr over a Wishbone classic initiator, one word at a time.
module wb_boot_copier
    import minsoc_wb_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int LEN_W   = 16
) (
    input  logic             wb_clk,
    input  logic             wb_rst,
    input  logic             start,
    input  logic [31:0]      src_adr,
    input  logic [31:0]      dst_adr,
    input  logic [LEN_W-1:0] len_words,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] words_done,
    output logic [31:0]      wb_adr_o,
    output logic [31:0]      wb_dat_o,
    input  logic [31:0]      wb_dat_i,
    output logic             wb_we_o,
    output logic [3:0]       wb_sel_o,
    output logic             wb_stb_o,
    output logic             wb_cyc_o,
    input  logic             wb_ack_i,
    input  logic             wb_err_i
);

    copier_state_t    state_reg, state_next;
    logic [31:0]      src_reg, src_next;
    logic [31:0]      dst_reg, dst_next;
    logic [LEN_W-1:0] remain_reg, remain_next;
    logic [LEN_W-1:0] words_done_reg, words_done_next;
    logic             err_reg, err_next;
    logic             busy_reg, done_reg;

    logic             launch, launch_we;
    logic [31:0]      launch_adr, launch_dat;
    logic             xfer_ok, xfer_fail;
    logic [31:0]      rd_data;

    minsoc_wb_xfer #(.TIMEOUT(TIMEOUT)) u_xfer (
        .wb_clk     (wb_clk),
        .wb_rst     (wb_rst),
        .launch     (launch),
        .launch_we  (launch_we),
        .launch_adr (launch_adr),
        .launch_dat (launch_dat),
        .xfer_ok    (xfer_ok),
        .xfer_fail  (xfer_fail),
        .rd_data    (rd_data),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_dat_i   (wb_dat_i),
        .wb_we_o    (wb_we_o),
        .wb_sel_o   (wb_sel_o),
        .wb_stb_o   (wb_stb_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_ack_i   (wb_ack_i),
        .wb_err_i   (wb_err_i)
    );

    // Transfers are launched on the same edge the FSM enters RD/WR so that stb
    // is valid in the first cycle of those states.
    always_comb begin
        state_next      = state_reg;
        src_next        = src_reg;
        dst_next        = dst_reg;
        remain_next     = remain_reg;
        words_done_next = words_done_reg;
        err_next        = err_reg;
        launch          = 1'b0;
        launch_we       = 1'b0;
        launch_adr      = src_reg;
        launch_dat      = rd_data;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    src_next        = word_align(src_adr);
                    dst_next        = word_align(dst_adr);
                    remain_next     = len_words;
                    words_done_next = '0;
                    err_next        = 1'b0;
                    if (len_words == '0) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_RD;
                        launch     = 1'b1;
                        launch_adr = src_next;
                    end
                end
            end
            ST_RD: begin
                if (xfer_fail) begin
                    err_next   = 1'b1;
                    state_next = ST_DONE;
                end else if (xfer_ok) begin
                    state_next = ST_GAP_R;
                end
            end
            ST_GAP_R: begin
                state_next = ST_WR;
                launch     = 1'b1;
                launch_we  = 1'b1;
                launch_adr = dst_reg;
            end
            ST_WR: begin
                if (xfer_fail) begin
                    err_next   = 1'b1;
                    state_next = ST_DONE;
                end else if (xfer_ok) begin
                    words_done_next = words_done_reg + LEN_W'(1);
                    remain_next     = remain_reg - LEN_W'(1);
                    state_next      = ST_GAP_W;
                end
            end
            ST_GAP_W: begin
                src_next = src_reg + WB_ADR_INC;
                dst_next = dst_reg + WB_ADR_INC;
                if (remain_reg == '0) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_RD;
                    launch     = 1'b1;
                    launch_adr = src_next;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_reg      <= ST_IDLE;
            src_reg        <= '0;
            dst_reg        <= '0;
            remain_reg     <= '0;
            words_done_reg <= '0;
            err_reg        <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            src_reg        <= src_next;
            dst_reg        <= dst_next;
            remain_reg     <= remain_next;
            words_done_reg <= words_done_next;
            err_reg        <= err_next;
            busy_reg       <= (state_next == ST_RD) || (state_next == ST_GAP_R) ||
                              (state_next == ST_WR) || (state_next == ST_GAP_W);
            done_reg       <= (state_next == ST_DONE);
        end
    end

    assign busy       = busy_reg;
    assign done       = done_reg;
    assign err        = err_reg;
    assign words_done = words_done_reg;

endmodule

// File: tb/tb_wb_boot_copier.sv
// Bench for wb_boot_copier: negedge slave/monitor with a scoreboard of expected
// completed bus transfers, plus per-copy status and latency checks.
module tb_wb_boot_copier;

    localparam int TIMEOUT = 8;
    localparam int LEN_W   = 16;

    logic             wb_clk = 1'b0;
    logic             wb_rst = 1'b1;
    logic             start = 1'b0;
    logic [31:0]      src_adr = '0;
    logic [31:0]      dst_adr = '0;
    logic [LEN_W-1:0] len_words = '0;
    logic             busy, done, err;
    logic [LEN_W-1:0] words_done;
    logic [31:0]      wb_adr_o, wb_dat_o;
    logic [31:0]      wb_dat_i = '0;
    logic             wb_we_o, wb_stb_o, wb_cyc_o;
    logic [3:0]       wb_sel_o;
    logic             wb_ack_i = 1'b0;
    logic             wb_err_i = 1'b0;

    always #5 wb_clk = ~wb_clk;

    wb_boot_copier #(.TIMEOUT(TIMEOUT), .LEN_W(LEN_W)) dut (
        .wb_clk     (wb_clk),
        .wb_rst     (wb_rst),
        .start      (start),
        .src_adr    (src_adr),
        .dst_adr    (dst_adr),
        .len_words  (len_words),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .words_done (words_done),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_dat_i   (wb_dat_i),
        .wb_we_o    (wb_we_o),
        .wb_sel_o   (wb_sel_o),
        .wb_stb_o   (wb_stb_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_ack_i   (wb_ack_i),
        .wb_err_i   (wb_err_i)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } xact_t;

    xact_t exp_q[$];
    xact_t mon_e;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pattern(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Slave behaviour knobs
    int err_on_read = 0;
    bit never_ack   = 1'b0;
    bit stray_ack   = 1'b0;
    int rd_attempts = 0;
    int stb_cnt     = 0;
    int stb_run     = 0;
    int last_run    = 0;
    bit stb_seen    = 1'b0;
    bit err_pend    = 1'b0;

    // Slave answers in the second strobed cycle; monitor retires acked transfers.
    always @(negedge wb_clk) begin
        if (err_pend) begin
            check_eq("stb_after_err", wb_stb_o, 0);
            err_pend = 1'b0;
        end
        if (wb_stb_o || wb_cyc_o) begin
            check_eq("cyc_eq_stb", wb_cyc_o, wb_stb_o);
            check_eq("sel", wb_sel_o, 4'hF);
        end
        if (wb_stb_o) begin
            stb_run++;
            stb_seen = 1'b1;
        end else if (stb_run != 0) begin
            last_run = stb_run;
            stb_run  = 0;
        end
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = '0;
        if (wb_stb_o) begin
            stb_cnt++;
            if (stb_cnt == 2 && !never_ack) begin
                if (!wb_we_o) rd_attempts++;
                if (!wb_we_o && rd_attempts == err_on_read) begin
                    wb_err_i = 1'b1;
                end else begin
                    wb_ack_i = 1'b1;
                    if (!wb_we_o) wb_dat_i = pattern(wb_adr_o);
                end
            end
        end else begin
            stb_cnt  = 0;
            wb_ack_i = stray_ack;
        end
        if (wb_stb_o && wb_err_i) err_pend = 1'b1;
        if (wb_stb_o && wb_ack_i && !wb_err_i) begin
            if (exp_q.size() == 0) begin
                check_eq("xfer_expected", exp_q.size(), 1);
            end else begin
                mon_e = exp_q.pop_front();
                $display("[TB] xfer we=%0d adr=0x%08h dat=0x%08h", wb_we_o, wb_adr_o,
                         wb_we_o ? wb_dat_o : wb_dat_i);
                check_eq("xfer_we", wb_we_o, mon_e.we);
                check_eq("xfer_adr", wb_adr_o, mon_e.adr);
                check_eq("xfer_dat", wb_we_o ? wb_dat_o : wb_dat_i, mon_e.dat);
            end
        end
    end

    task automatic push_copy(input logic [31:0] src, input logic [31:0] dst, input int n);
        logic [31:0] s;
        for (int i = 0; i < n; i++) begin
            s = src + 32'(4 * i);
            exp_q.push_back('{we: 1'b0, adr: s, dat: pattern(s)});
            exp_q.push_back('{we: 1'b1, adr: dst + 32'(4 * i), dat: pattern(s)});
        end
    endtask

    // Called #1 after an edge; returns #1 after the edge that accepted start.
    task automatic start_copy(input logic [31:0] src, input logic [31:0] dst, input int n);
        src_adr   = src;
        dst_adr   = dst;
        len_words = LEN_W'(n);
        start     = 1'b1;
        @(posedge wb_clk);
        #1;
        start = 1'b0;
    endtask

    // Latency is counted in edges after the one that accepted start.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 2000) begin
            @(posedge wb_clk);
            #1;
            lat++;
        end
        check_eq("done_seen", done, 1);
    endtask

    task automatic finish_checks(input logic exp_err, input int exp_words);
        check_eq("err", err, exp_err);
        check_eq("words_done", words_done, exp_words);
        check_eq("busy_at_done", busy, 0);
        @(posedge wb_clk);
        #1;
        check_eq("done_one_cycle", done, 0);
        check_eq("scoreboard_empty", exp_q.size(), 0);
    endtask

    initial begin
        int lat;
        int guard;

        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int guard;

        repeat (3) @(posedge wb_clk);
        #1;
        check_eq("rst_stb", wb_stb_o, 0);
        check_eq("rst_cyc", wb_cyc_o, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_words", words_done, 0);
        check_eq("rst_adr", wb_adr_o, 0);
        wb_rst = 1'b0;
        @(posedge wb_clk);
        #1;

        // Three words, 1-cycle-late acks: 6 edges per word.
        push_copy(32'h0, 32'h100, 3);
        start_copy(32'h0, 32'h100, 3);
        check_eq("busy_after_start", busy, 1);
        wait_done(lat);
        $display("[TB] copy len=3 done after %0d edges", lat);
        check_eq("len3_latency", lat, 18);
        finish_checks(1'b0, 3);

        // Zero length: straight to DONE, no bus activity.
        stb_seen = 1'b0;
        start_copy(32'h40, 32'h140, 0);
        wait_done(lat);
        $display("[TB] copy len=0 done after %0d edges", lat);
        check_eq("len0_latency", lat, 0);
        finish_checks(1'b0, 0);
        check_eq("len0_no_stb", stb_seen, 0);

        // Bus error on the second read.
        push_copy(32'h400, 32'h500, 1);
        rd_attempts = 0;
        err_on_read = 2;
        start_copy(32'h400, 32'h500, 4);
        wait_done(lat);
        $display("[TB] copy len=4 with read error done after %0d edges", lat);
        finish_checks(1'b1, 1);
        err_on_read = 0;
        check_eq("err_sticky", err, 1);

        // Slave never answers: read times out after TIMEOUT strobed cycles.
        never_ack = 1'b1;
        start_copy(32'h600, 32'h700, 1);
        check_eq("err_cleared_on_start", err, 0);
        wait_done(lat);
        $display("[TB] copy with silent slave done after %0d edges", lat);
        check_eq("timeout_latency", lat, TIMEOUT);
        finish_checks(1'b1, 0);
        check_eq("timeout_stb_len", last_run, TIMEOUT);
        never_ack = 1'b0;

        // Reset in the first cycle of the second write.
        push_copy(32'h800, 32'h900, 1);
        exp_q.push_back('{we: 1'b0, adr: 32'h804, dat: pattern(32'h804)});
        start_copy(32'h800, 32'h900, 3);
        guard = 0;
        while (!(wb_stb_o && wb_we_o && wb_adr_o == 32'h904) && guard < 200) begin
            @(posedge wb_clk);
            #1;
            guard++;
        end
        check_eq("second_write_seen", wb_adr_o, 32'h904);
        wb_rst = 1'b1;
        @(posedge wb_clk);
        #1;
        $display("[TB] reset applied during second write");
        check_eq("mid_rst_stb", wb_stb_o, 0);
        check_eq("mid_rst_cyc", wb_cyc_o, 0);
        check_eq("mid_rst_we", wb_we_o, 0);
        check_eq("mid_rst_adr", wb_adr_o, 0);
        check_eq("mid_rst_dat", wb_dat_o, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_done", done, 0);
        check_eq("mid_rst_err", err, 0);
        check_eq("mid_rst_words", words_done, 0);
        wb_rst = 1'b0;
        check_eq("mid_rst_scoreboard", exp_q.size(), 0);
        stb_seen = 1'b0;
        repeat (5) @(posedge wb_clk);
        #1;
        check_eq("no_resume_stb", stb_seen, 0);
        check_eq("no_resume_busy", busy, 0);
        push_copy(32'hA00, 32'hB00, 1);
        start_copy(32'hA00, 32'hB00, 1);
        wait_done(lat);
        $display("[TB] copy len=1 after reset done after %0d edges", lat);
        check_eq("len1_latency", lat, 6);
        finish_checks(1'b0, 1);

        // Source wraps past 2^32; a start while busy and stray acks are ignored.
        stray_ack = 1'b1;
        push_copy(32'hFFFF_FFFC, 32'hC00, 2);
        start_copy(32'hFFFF_FFFC, 32'hC00, 2);
        repeat (3) @(posedge wb_clk);
        #1;
        start_copy(32'h40, 32'hD00, 5);
        wait_done(lat);
        $display("[TB] wrapping copy done");
        finish_checks(1'b0, 2);
        stray_ack = 1'b0;
        repeat (20) @(posedge wb_clk);
        #1;
        check_eq("no_queued_start", busy, 0);
        check_eq("wrap_scoreboard", exp_q.size(), 0);
        check_eq("wrap_words_kept", words_done, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
